// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, hazard FSM states, reset PC and
// the per-opcode register-use decode.
package pipe_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Fetch restarts here; instruction_decode uses the same value.
  localparam logic [31:0] RESET_PC = 32'h00400000;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Which register fields an opcode actually reads or writes.
  typedef struct packed {
    logic rs1;
    logic rs2;
    logic rd;
  } use_t;

  function automatic use_t decode_use(input logic [6:0] opcode);
    use_t u;
    u = '0;
    case (opcode)
      OP_RTYPE: begin
        u.rs1 = 1'b1;
        u.rs2 = 1'b1;
        u.rd  = 1'b1;
      end
      OP_IALU, OP_LOAD, OP_JALR: begin
        u.rs1 = 1'b1;
        u.rd  = 1'b1;
      end
      OP_STORE, OP_BRANCH: begin
        u.rs1 = 1'b1;
        u.rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC, OP_JAL: begin
        u.rd = 1'b1;
      end
      default: u = '0;  // unknown opcodes touch no registers
    endcase
    return u;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Destination-register scoreboard: a DEPTH-entry shift register of
// {valid, rd} for instructions past decode, plus the busy-register mask.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [4:0]  rd,
  output logic [31:0] busy_mask
);

  logic       valid_reg [DEPTH];
  logic [4:0] rd_reg    [DEPTH];
  logic [31:0] onehot   [DEPTH];

  // Shift every cycle; entry 0 takes the issued destination or a bubble.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_reg[i] <= 1'b0;
        rd_reg[i]    <= 5'd0;
      end
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        valid_reg[i] <= valid_reg[i-1];
        rd_reg[i]    <= rd_reg[i-1];
      end
      if (load && rd != 5'd0) begin
        valid_reg[0] <= 1'b1;
        rd_reg[0]    <= rd;
      end else begin
        valid_reg[0] <= 1'b0;
        rd_reg[0]    <= 5'd0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_onehot
      assign onehot[gi] = valid_reg[gi] ? (32'd1 << rd_reg[gi]) : 32'd0;
    end
  endgenerate

  // Merge the per-entry one-hot decodes into the busy mask.
  always_comb begin
    busy_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_mask = busy_mask | onehot[i];
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Decode-stage sequencer for the non-forwarding in-order pipeline:
// RAW stall detection, branch-redirect flush and a stall-cycle counter.
module hazard_controller
  import pipe_pkg::*;
#(
  parameter int DEPTH        = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [6:0]  id_opcode,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        stall,
  output logic        succ,
  output logic        issue,
  output logic        pc_sel,
  output logic [31:0] pc_target,
  output logic [31:0] busy_mask,
  output logic [31:0] stall_count
);

  // Remaining flush cycles after the redirect cycle itself.
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [2:0]  fcnt_reg, fcnt_next;
  logic [31:0] stall_count_reg;
  logic [31:0] busy_raw;
  use_t        use_id;
  logic        hazard, sb_load;
  logic        stall_raw, issue_raw, succ_raw, pc_sel_raw;

  assign use_id = decode_use(id_opcode);

  assign hazard = id_valid &
                  ((use_id.rs1 & (id_rs1 != 5'd0) & busy_raw[id_rs1]) |
                   (use_id.rs2 & (id_rs2 != 5'd0) & busy_raw[id_rs2]));

  assign sb_load = issue & use_id.rd & (id_rd != 5'd0);

  hazard_scoreboard #(
    .DEPTH(DEPTH)
  ) u_scoreboard (
    .clock     (clock),
    .reset     (reset),
    .load      (sb_load),
    .rd        (id_rd),
    .busy_mask (busy_raw)
  );

  // State and flush counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= RUN;
      fcnt_reg  <= 3'd0;
    end else begin
      state_reg <= state_next;
      fcnt_reg  <= fcnt_next;
    end
  end

  // Next state and raw outputs; redirect beats flush beats hazard beats issue.
  always_comb begin
    state_next = state_reg;
    fcnt_next  = fcnt_reg;
    stall_raw  = 1'b0;
    issue_raw  = 1'b0;
    succ_raw   = 1'b0;
    pc_sel_raw = 1'b0;
    case (state_reg)
      RUN: begin
        if (redirect) begin
          succ_raw   = 1'b1;
          pc_sel_raw = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_next = FLUSH;
            fcnt_next  = FLUSH_RELOAD;
          end
        end else if (hazard) begin
          stall_raw = 1'b1;
        end else begin
          issue_raw = id_valid;
        end
      end
      FLUSH: begin
        succ_raw = 1'b1;
        if (redirect) begin
          pc_sel_raw = 1'b1;
          fcnt_next  = FLUSH_RELOAD;
        end else if (fcnt_reg <= 3'd1) begin
          state_next = RUN;
          fcnt_next  = 3'd0;
        end else begin
          fcnt_next = fcnt_reg - 3'd1;
        end
      end
      default: begin
        state_next = RUN;
        fcnt_next  = 3'd0;
      end
    endcase
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_count_reg <= 32'd0;
    end else if (stall && stall_count_reg != 32'hFFFFFFFF) begin
      stall_count_reg <= stall_count_reg + 32'd1;
    end
  end

  // Everything visible is held at zero while reset is low.
  assign stall       = reset & stall_raw;
  assign issue       = reset & issue_raw;
  assign succ        = reset & succ_raw;
  assign pc_sel      = reset & pc_sel_raw;
  assign pc_target   = pc_sel ? redirect_pc : 32'd0;
  assign busy_mask   = reset ? busy_raw : 32'd0;
  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: a register-age reference model
// predicts every cycle's outputs, a monitor compares them at the falling edge.
`timescale 1ns/1ps
module tb_hazard_controller;

  localparam int DEPTH        = 3;
  localparam int FLUSH_CYCLES = 2;

  localparam logic [6:0] T_R     = 7'b0110011;
  localparam logic [6:0] T_IALU  = 7'b0010011;
  localparam logic [6:0] T_LOAD  = 7'b0000011;
  localparam logic [6:0] T_STORE = 7'b0100011;
  localparam logic [6:0] T_LUI   = 7'b0110111;

  logic        clock = 1'b0;
  logic        reset, id_valid, redirect;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] redirect_pc;
  logic        stall, succ, issue, pc_sel;
  logic [31:0] pc_target, busy_mask, stall_count;

  always #5 clock = ~clock;

  hazard_controller #(
    .DEPTH(DEPTH),
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall(stall), .succ(succ), .issue(issue),
    .pc_sel(pc_sel), .pc_target(pc_target), .busy_mask(busy_mask),
    .stall_count(stall_count)
  );

  typedef struct packed {
    logic        stall;
    logic        issue;
    logic        succ;
    logic        pc_sel;
    logic [31:0] pc_target;
    logic [31:0] busy;
    logic [31:0] stall_count;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: cycles each register stays busy, flush cycles still owed.
  int          busy_age [32];
  int          succ_left;
  logic [31:0] m_stall_count;

  exp_t        cur_e;
  logic        cur_rst, cur_redir, cur_writes;
  logic [4:0]  cur_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // {reads rs1, reads rs2, writes rd}
  function automatic logic [2:0] model_use(input logic [6:0] op);
    case (op)
      7'b0110011:                         return 3'b111;
      7'b0010011, 7'b0000011, 7'b1100111: return 3'b101;
      7'b0100011, 7'b1100011:             return 3'b110;
      7'b0110111, 7'b0010111, 7'b1101111: return 3'b001;
      default:                            return 3'b000;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd, input logic redir,
                       input logic [31:0] rpc, input logic rst);
    exp_t       e;
    logic [2:0] u;
    logic       haz;
    id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    redirect = redir; redirect_pc = rpc; reset = rst;
    u = model_use(op);
    e = '0;
    e.stall_count = m_stall_count;
    if (rst) begin
      for (int r = 1; r < 32; r++) if (busy_age[r] > 0) e.busy[r] = 1'b1;
      haz = v && ((u[2] && r1 != 5'd0 && busy_age[r1] > 0) ||
                  (u[1] && r2 != 5'd0 && busy_age[r2] > 0));
      if (redir) begin
        e.succ = 1'b1; e.pc_sel = 1'b1; e.pc_target = rpc;
      end else if (succ_left > 0) begin
        e.succ = 1'b1;
      end else if (haz) begin
        e.stall = 1'b1;
      end else begin
        e.issue = v;
      end
    end
    expq.push_back(e);
    cur_e = e; cur_rst = rst; cur_redir = redir; cur_rd = rd; cur_writes = u[0];
    #1;
  endtask

  task automatic finish_cycle();
    @(posedge clock);
    if (!cur_rst) begin
      for (int r = 0; r < 32; r++) busy_age[r] = 0;
      succ_left = 0;
      m_stall_count = 32'd0;
    end else begin
      for (int r = 0; r < 32; r++) if (busy_age[r] > 0) busy_age[r]--;
      if (cur_e.issue && cur_writes && cur_rd != 5'd0) busy_age[cur_rd] = DEPTH;
      if (cur_redir) succ_left = FLUSH_CYCLES - 1;
      else if (succ_left > 0) succ_left--;
      if (cur_e.stall && m_stall_count != 32'hFFFFFFFF) m_stall_count++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1);
      finish_cycle();
    end
  endtask

  // Hold an instruction in decode until it issues; counts stalls seen on the DUT.
  task automatic run_instr(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] rd, output int stalls);
    logic done;
    stalls = 0;
    done   = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      drive(1'b1, op, r1, r2, rd, 1'b0, 32'd0, 1'b1);
      if (stall) stalls++;
      done = cur_e.issue;
      finish_cycle();
    end
    chk("issue_within_bound", {31'd0, done}, 32'd1);
  endtask

  // Monitor: one popped expectation per cycle, sampled at the falling edge.
  initial begin
    exp_t me;
    forever begin
      @(negedge clock);
      if (expq.size() > 0) begin
        me = expq.pop_front();
        chk("stall", {31'd0, stall}, {31'd0, me.stall});
        chk("issue", {31'd0, issue}, {31'd0, me.issue});
        chk("succ", {31'd0, succ}, {31'd0, me.succ});
        chk("pc_sel", {31'd0, pc_sel}, {31'd0, me.pc_sel});
        chk("pc_target", pc_target, me.pc_target);
        chk("busy_mask", busy_mask, me.busy);
        chk("stall_count", stall_count, me.stall_count);
        if (stall && succ) chk("stall_succ_exclusive", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s, cnt_succ, cnt_sel;
    logic [31:0] base;
    logic [6:0]  ops [10];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1111111};
    for (int r = 0; r < 32; r++) busy_age[r] = 0;
    succ_left = 0;
    m_stall_count = 32'd0;

    reset = 1'b0; id_valid = 1'b0; id_opcode = 7'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_rd = 5'd0; redirect = 1'b0; redirect_pc = 32'd0;
    repeat (2) @(posedge clock);
    #1;

    // Reset state, with a redirect request that must stay masked
    drive(1'b1, T_R, 5'd1, 5'd2, 5'd3, 1'b1, 32'h1234, 1'b0); finish_cycle();
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0);   finish_cycle();
    idle(1);

    // Back-to-back RAW: add x5,x1,x2 ; sub x6,x5,x3
    base = stall_count;
    run_instr(T_R, 5'd1, 5'd2, 5'd5, s);
    run_instr(T_R, 5'd5, 5'd3, 5'd6, s);
    chk("raw_stall_cycles", s, 32'd3);
    chk("raw_stall_count", stall_count - base, 32'd3);

    // x0 and non-reading opcodes
    idle(4);
    run_instr(T_IALU, 5'd0, 5'd0, 5'd0, s);
    run_instr(T_R, 5'd0, 5'd0, 5'd7, s);
    chk("x0_no_stall", s, 32'd0);
    run_instr(T_R, 5'd1, 5'd2, 5'd5, s);
    run_instr(T_LUI, 5'd5, 5'd5, 5'd5, s);
    chk("lui_no_stall", s, 32'd0);

    // Load then dependent store: lw x8 ; sw x8,0(x9)
    idle(4);
    run_instr(T_LOAD, 5'd1, 5'd0, 5'd8, s);
    run_instr(T_STORE, 5'd9, 5'd8, 5'd3, s);
    chk("store_stall_cycles", s, 32'd3);
    chk("store_no_busy", busy_mask, 32'd0);

    // Redirect arriving during a hazard stall
    idle(4);
    run_instr(T_R, 5'd1, 5'd2, 5'd5, s);
    drive(1'b1, T_R, 5'd5, 5'd3, 5'd6, 1'b0, 32'd0, 1'b1); finish_cycle();
    drive(1'b1, T_R, 5'd5, 5'd3, 5'd6, 1'b1, 32'h00400040, 1'b1);
    chk("redir_stall", {31'd0, stall}, 32'd0);
    chk("redir_succ", {31'd0, succ}, 32'd1);
    chk("redir_pc_sel", {31'd0, pc_sel}, 32'd1);
    chk("redir_pc_target", pc_target, 32'h00400040);
    finish_cycle();
    cnt_succ = 1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1);
      if (succ && cnt_succ == k + 1) cnt_succ++;
      finish_cycle();
    end
    chk("redir_succ_len", cnt_succ, FLUSH_CYCLES);

    // Second redirect on the flush cycle extends the flush
    idle(4);
    cnt_succ = 0; cnt_sel = 0;
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h00000100, 1'b1);
    if (succ) cnt_succ++;
    if (pc_sel) cnt_sel++;
    finish_cycle();
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h00000200, 1'b1);
    if (succ) cnt_succ++;
    if (pc_sel) cnt_sel++;
    chk("redir2_pc_target", pc_target, 32'h00000200);
    finish_cycle();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1);
      if (succ && cnt_succ == k + 2) cnt_succ++;
      if (pc_sel) cnt_sel++;
      finish_cycle();
    end
    chk("redir2_succ_len", cnt_succ, 32'd3);
    chk("redir2_pc_sel_pulses", cnt_sel, 32'd2);

    // Reset in the middle of a flush while x5 is busy
    idle(4);
    run_instr(T_R, 5'd1, 5'd2, 5'd5, s);
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h00000300, 1'b1); finish_cycle();
    drive(1'b1, T_R, 5'd5, 5'd5, 5'd9, 1'b1, 32'h00000400, 1'b0);
    chk("rst_succ", {31'd0, succ}, 32'd0);
    chk("rst_pc_sel", {31'd0, pc_sel}, 32'd0);
    chk("rst_pc_target", pc_target, 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_issue", {31'd0, issue}, 32'd0);
    finish_cycle();
    drive(1'b1, T_R, 5'd5, 5'd5, 5'd9, 1'b0, 32'd0, 1'b1);
    chk("post_rst_issue", {31'd0, issue}, 32'd1);
    chk("post_rst_succ", {31'd0, succ}, 32'd0);
    chk("post_rst_stall_count", stall_count, 32'd0);
    finish_cycle();

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      drive(($urandom_range(0, 3) != 0), ops[$urandom_range(0, 9)],
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 39) != 0));
      finish_cycle();
    end
    idle(2);

    repeat (2) @(negedge clock);
    chk("scoreboard_drained", expq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
